spi_tx_feeder: RTL

- Upstream feeder for the SPI master's `send`/`send_data`/`data_ready` interface.
- Buffers bytes from a producer (CPU or register block) in a small FIFO and issues one SPI transfer per byte.
- Holds `send_data` stable for the whole transfer, reports per-byte completion and flags overflow and stall errors.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_tx_feeder_if.sv | 31 +++
 rtl/spi_tx_feeder_byte_fifo.sv | 46 ++++
 rtl/spi_tx_feeder.sv | 110 +++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit feeder: byte width, defaults and FSM encoding.
package spi_pkg;
  localparam int SPI_BYTE_W  = 8;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE
  } feeder_state_e;
endpackage

// File: rtl/spi_tx_feeder_if.sv
// Producer / SPI-master facing signal bundle of the transmit feeder.
interface spi_tx_feeder_if #(
  parameter int DEPTH = 8
);
  import spi_pkg::*;
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  wr_en;
  logic [SPI_BYTE_W-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [LW-1:0]         level;
  logic                  send;
  logic [SPI_BYTE_W-1:0] send_data;
  logic                  data_ready;
  logic                  busy;
  logic                  byte_done;
  logic                  overflow;
  logic                  stall_err;
  logic                  clr_err;

  modport slave (
    input  wr_en, wr_data, data_ready, clr_err,
    output full, empty, level, send, send_data, busy, byte_done, overflow, stall_err
  );

  modport master (
    output wr_en, wr_data, data_ready, clr_err,
    input  full, empty, level, send, send_data, busy, byte_done, overflow, stall_err
  );
endinterface

// File: rtl/spi_tx_feeder_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; status flags derive only from registered pointers.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // full is judged on pre-pop state, so a write while full is dropped even if a pop coincides
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/spi_tx_feeder.sv
// Feeds queued bytes to an SPI master one transfer at a time, with overflow/stall reporting.
module spi_tx_feeder
  import spi_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic            clk_i,
  input logic            rst_i,
  spi_tx_feeder_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  feeder_state_e         state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SPI_BYTE_W-1:0] send_data_q, send_data_d;
  logic                  byte_done_q, byte_done_d;
  logic                  ovf_q, ovf_d;
  logic                  stall_q, stall_d;
  logic                  stall_set, pop;

  logic                  fifo_full, fifo_empty;
  logic [LW-1:0]         fifo_level;
  logic [SPI_BYTE_W-1:0] fifo_rdata;

  byte_fifo #(.DEPTH(DEPTH), .W(SPI_BYTE_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (bus.wr_en),
    .wdata_i (bus.wr_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    send_data_d = send_data_q;
    byte_done_d = 1'b0;
    stall_set   = 1'b0;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && bus.data_ready) begin
          pop         = 1'b1;
          send_data_d = fifo_rdata;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (!bus.data_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT_START;
        end else if (cnt_d == CNT_MAX) begin
          // master never took the request: the byte is abandoned
          cnt_d     = '0;
          stall_set = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      // one dead cycle so the master cannot see send twice
      ST_WAIT_START: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (bus.data_ready) begin
          byte_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ovf_d   = (bus.wr_en && fifo_full) ? 1'b1 : (bus.clr_err ? 1'b0 : ovf_q);
    stall_d = stall_set ? 1'b1 : (bus.clr_err ? 1'b0 : stall_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      send_data_q <= '0;
      byte_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      send_data_q <= send_data_d;
      byte_done_q <= byte_done_d;
      ovf_q       <= ovf_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.level     = fifo_level;
  assign bus.send      = (state_q == ST_ISSUE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.send_data = send_data_q;
  assign bus.byte_done = byte_done_q;
  assign bus.overflow  = ovf_q;
  assign bus.stall_err = stall_q;
endmodule
